// File: rtl/bnn_stream_scheduler.sv
// Batch sequencer for the BNN streaming datapath: issues indexed vectors to stage 1
// under credit-based flow control, counts last-stage retirements and reports done/abort.
module bnn_stream_scheduler #(
   parameter int TOTAL_INPUTS = 16,
   parameter int MAX_INFLIGHT = 4,
   localparam int IW = $clog2(TOTAL_INPUTS),
   localparam int CW = $clog2(TOTAL_INPUTS + 1),
   localparam int FW = $clog2(MAX_INFLIGHT + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          abort,
   input  logic [CW-1:0] cfg_count,
   output logic          issue_valid,
   input  logic          issue_ready,
   output logic [IW-1:0] issue_index,
   input  logic          result_valid,
   output logic [FW-1:0] inflight,
   output logic          busy,
   output logic          done,
   output logic          aborted,
   output logic          err_underflow
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RUN   = 3'd1,
      DRAIN = 3'd2,
      FLUSH = 3'd3,
      FIN   = 3'd4
   } state_t;

   localparam logic [CW-1:0] TOTAL_C = CW'(TOTAL_INPUTS);
   localparam logic [FW-1:0] MAX_C   = FW'(MAX_INFLIGHT);

   state_t        state_r, state_next_s;
   logic [CW-1:0] n_r, n_next_s, n_clamp_s;
   logic [CW-1:0] issued_r, issued_next_s;
   logic [CW-1:0] retired_r, retired_next_s;
   logic [FW-1:0] inflight_r, inflight_next_s;
   logic [IW-1:0] index_r;
   logic          done_r, aborted_r, err_r;
   logic          issue_fire_s, retire_ok_s, underflow_s;

   assign n_clamp_s    = (cfg_count > TOTAL_C) ? TOTAL_C : cfg_count;
   assign issue_valid  = (state_r == RUN) && (issued_r < n_r) && (inflight_r < MAX_C);
   assign issue_fire_s = issue_valid && issue_ready;
   assign underflow_s  = result_valid && (inflight_r == {FW{1'b0}});
   assign retire_ok_s  = result_valid && (inflight_r != {FW{1'b0}}) &&
                         (state_r inside {RUN, DRAIN, FLUSH});

   assign busy          = (state_r != IDLE);
   assign issue_index   = index_r;
   assign inflight      = inflight_r;
   assign done          = done_r;
   assign aborted       = aborted_r;
   assign err_underflow = err_r;

   // Next-state decode; abort outranks the completion transitions.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE: begin
            // An empty batch passes through DRAIN so done lands on the second cycle after start.
            if (start && (n_clamp_s == {CW{1'b0}})) state_next_s = DRAIN;
            else if (start)                         state_next_s = RUN;
            else                                    state_next_s = IDLE;
         end
         RUN: begin
            if (abort)                                             state_next_s = FLUSH;
            else if (issue_fire_s && (issued_r + CW'(1) == n_r))   state_next_s = DRAIN;
            else                                                   state_next_s = RUN;
         end
         DRAIN: begin
            if (abort)                                             state_next_s = FLUSH;
            else if ((retired_r == n_r) ||
                     (retire_ok_s && (retired_r + CW'(1) == n_r))) state_next_s = FIN;
            else                                                   state_next_s = DRAIN;
         end
         FLUSH: begin
            if (inflight_r == {FW{1'b0}}) state_next_s = IDLE;
            else                          state_next_s = FLUSH;
         end
         FIN:     state_next_s = IDLE;
         default: state_next_s = IDLE;
      endcase
   end

   // Batch size, issue/retire counters and credit count for the next cycle.
   always_comb begin
      n_next_s        = n_r;
      issued_next_s   = issued_r;
      retired_next_s  = retired_r;
      inflight_next_s = inflight_r;
      if ((state_r == IDLE) && start) begin
         n_next_s       = n_clamp_s;
         issued_next_s  = {CW{1'b0}};
         retired_next_s = {CW{1'b0}};
      end else begin
         if (issue_fire_s) issued_next_s  = issued_r + CW'(1);
         else              issued_next_s  = issued_r;
         if (retire_ok_s)  retired_next_s = retired_r + CW'(1);
         else              retired_next_s = retired_r;
      end
      case ({issue_fire_s, retire_ok_s})
         2'b10:   inflight_next_s = inflight_r + FW'(1);
         2'b01:   inflight_next_s = inflight_r - FW'(1);
         default: inflight_next_s = inflight_r;
      endcase
   end

   // State, counters and registered status pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= IDLE;
         n_r        <= {CW{1'b0}};
         issued_r   <= {CW{1'b0}};
         retired_r  <= {CW{1'b0}};
         inflight_r <= {FW{1'b0}};
         index_r    <= {IW{1'b0}};
         done_r     <= 1'b0;
         aborted_r  <= 1'b0;
         err_r      <= 1'b0;
      end else begin
         state_r    <= state_next_s;
         n_r        <= n_next_s;
         issued_r   <= issued_next_s;
         retired_r  <= retired_next_s;
         inflight_r <= inflight_next_s;
         index_r    <= issued_next_s[IW-1:0];
         done_r     <= (state_next_s == FIN);
         aborted_r  <= (state_next_s == FLUSH) && (inflight_next_s == {FW{1'b0}});
         err_r      <= err_r | underflow_s;
      end
   end

endmodule

// File: tb/tb_bnn_stream_scheduler.sv
// Self-checking bench for bnn_stream_scheduler: directed scenarios plus a randomized
// run compared cycle by cycle against a counter-level reference model.
module tb_bnn_stream_scheduler;
   localparam int TI = 16;
   localparam int MI = 4;
   localparam int IW = 4;
   localparam int CW = 5;
   localparam int FW = 3;

   logic          clk = 1'b0;
   logic          rst_n, start, abort, issue_ready, result_valid;
   logic [CW-1:0] cfg_count;
   logic          issue_valid, busy, done, aborted, err_underflow;
   logic [IW-1:0] issue_index;
   logic [FW-1:0] inflight;
   int            checks = 0;
   int            passed = 0;

   always #5 clk = ~clk;

   bnn_stream_scheduler #(.TOTAL_INPUTS(TI), .MAX_INFLIGHT(MI)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .cfg_count(cfg_count),
      .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_index(issue_index),
      .result_valid(result_valid), .inflight(inflight), .busy(busy), .done(done),
      .aborted(aborted), .err_underflow(err_underflow)
   );

   task automatic drive_idle();
      start = 1'b0; abort = 1'b0; issue_ready = 1'b0; result_valid = 1'b0; cfg_count = '0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive_idle();
      repeat (2) @(negedge clk);
      checks++; if (issue_valid !== 1'b0) $display("FAIL reset_issue_valid got=%0b exp=0", issue_valid); else passed++;
      checks++; if (issue_index !== 4'd0) $display("FAIL reset_issue_index got=%0d exp=0", issue_index); else passed++;
      checks++; if (inflight !== 3'd0) $display("FAIL reset_inflight got=%0d exp=0", inflight); else passed++;
      checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%0b exp=0", busy); else passed++;
      checks++; if ({done, aborted, err_underflow} !== 3'b000) $display("FAIL reset_flags got=%b exp=000", {done, aborted, err_underflow}); else passed++;
      rst_n = 1'b1;
      @(negedge clk);
      checks++; if (busy !== 1'b0) $display("FAIL reset_release_busy got=%0b exp=0", busy); else passed++;
   endtask

   // T1: full batch of 16, ready always high, results three cycles after issue.
   task automatic test_full_batch();
      int due[$];
      int exp_idx = 0;
      int max_inf = 0;
      int extra_done = 0;
      bit finished = 1'b0;
      drive_idle();
      start = 1'b1; cfg_count = 5'd16;
      @(negedge clk);
      start = 1'b0; issue_ready = 1'b1;
      checks++; if (issue_valid !== 1'b1) $display("FAIL t1_first_issue got=%0b exp=1", issue_valid); else passed++;
      for (int cyc = 0; cyc < 100 && !finished; cyc++) begin
         if (int'(inflight) > max_inf) max_inf = int'(inflight);
         if (done) begin
            finished = 1'b1;
            checks++; if (busy !== 1'b1) $display("FAIL t1_busy_at_done got=%0b exp=1", busy); else passed++;
         end else begin
            if (issue_valid) begin
               checks++; if (issue_index !== exp_idx[IW-1:0]) $display("FAIL t1_index got=%0d exp=%0d", issue_index, exp_idx); else passed++;
               exp_idx++;
               due.push_back(cyc + 3);
            end
            result_valid = 1'b0;
            if (due.size() > 0) begin
               if (due[0] == cyc) begin
                  result_valid = 1'b1;
                  void'(due.pop_front());
               end
            end
            @(negedge clk);
         end
      end
      result_valid = 1'b0; issue_ready = 1'b0;
      checks++; if (!finished) $display("FAIL t1_done_timeout got=0 exp=1"); else passed++;
      checks++; if (exp_idx != 16) $display("FAIL t1_issue_count got=%0d exp=16", exp_idx); else passed++;
      checks++; if (max_inf != 3) $display("FAIL t1_max_inflight got=%0d exp=3", max_inf); else passed++;
      @(negedge clk);
      checks++; if (busy !== 1'b0) $display("FAIL t1_busy_after_done got=%0b exp=0", busy); else passed++;
      repeat (5) begin
         if (done) extra_done++;
         @(negedge clk);
      end
      checks++; if (extra_done != 0) $display("FAIL t1_extra_done got=%0d exp=0", extra_done); else passed++;
   endtask

   // T2: credits run out after four issues; each retirement releases exactly one more issue.
   task automatic test_credit_stall();
      int cnt = 0;
      drive_idle();
      start = 1'b1; cfg_count = 5'd8;
      @(negedge clk);
      start = 1'b0;
      repeat (3) begin
         checks++; if (issue_valid !== 1'b1 || issue_index !== 4'd0) $display("FAIL t2_hold got=%0b/%0d exp=1/0", issue_valid, issue_index); else passed++;
         @(negedge clk);
      end
      issue_ready = 1'b1;
      for (int k = 0; k < 10; k++) begin
         if (issue_valid) cnt++;
         @(negedge clk);
      end
      checks++; if (cnt != 4) $display("FAIL t2_issues_before_stall got=%0d exp=4", cnt); else passed++;
      checks++; if (inflight !== 3'd4 || issue_valid !== 1'b0) $display("FAIL t2_stalled got=%0d/%0b exp=4/0", inflight, issue_valid); else passed++;
      for (int r = 0; r < 4; r++) begin
         result_valid = 1'b1;
         @(negedge clk);
         result_valid = 1'b0;
         checks++; if (inflight !== 3'd3 || issue_valid !== 1'b1) $display("FAIL t2_credit_free got=%0d/%0b exp=3/1", inflight, issue_valid); else passed++;
         @(negedge clk);
         checks++; if (inflight !== 3'd4 || issue_valid !== 1'b0 || int'(issue_index) != 5 + r) $display("FAIL t2_credit_used got=%0d/%0b/%0d exp=4/0/%0d", inflight, issue_valid, issue_index, 5 + r); else passed++;
      end
      for (int k = 0; k < 4; k++) begin
         checks++; if (done !== 1'b0) $display("FAIL t2_early_done got=%0b exp=0", done); else passed++;
         result_valid = 1'b1;
         @(negedge clk);
      end
      result_valid = 1'b0; issue_ready = 1'b0;
      checks++; if (done !== 1'b1 || inflight !== 3'd0) $display("FAIL t2_done got=%0b/%0d exp=1/0", done, inflight); else passed++;
      @(negedge clk);
      checks++; if (busy !== 1'b0) $display("FAIL t2_idle got=%0b exp=0", busy); else passed++;
   endtask

   // T3: empty batch.
   task automatic test_empty_batch();
      drive_idle();
      issue_ready = 1'b1;
      start = 1'b1; cfg_count = 5'd0;
      @(negedge clk);
      start = 1'b0;
      checks++; if ({busy, done, issue_valid} !== 3'b100) $display("FAIL t3_cycle1 got=%b exp=100", {busy, done, issue_valid}); else passed++;
      @(negedge clk);
      checks++; if ({busy, done, issue_valid} !== 3'b110) $display("FAIL t3_cycle2 got=%b exp=110", {busy, done, issue_valid}); else passed++;
      @(negedge clk);
      checks++; if ({busy, done} !== 2'b00) $display("FAIL t3_cycle3 got=%b exp=00", {busy, done}); else passed++;
      issue_ready = 1'b0;
   endtask

   // T4: abort with three vectors in flight.
   task automatic test_abort();
      bit seen_done = 1'b0;
      drive_idle();
      start = 1'b1; cfg_count = 5'd10;
      @(negedge clk);
      start = 1'b0; issue_ready = 1'b1;
      repeat (3) @(negedge clk);
      result_valid = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (issue_index !== 4'd5 || inflight !== 3'd3) $display("FAIL t4_pre_abort got=%0d/%0d exp=5/3", issue_index, inflight); else passed++;
      abort = 1'b1; issue_ready = 1'b0; result_valid = 1'b0;
      @(negedge clk);
      abort = 1'b0; issue_ready = 1'b1;
      checks++; if ({busy, issue_valid, aborted} !== 3'b100 || inflight !== 3'd3) $display("FAIL t4_flush_entry got=%b/%0d exp=100/3", {busy, issue_valid, aborted}, inflight); else passed++;
      for (int k = 0; k < 3; k++) begin
         result_valid = 1'b1;
         @(negedge clk);
         seen_done |= done;
         checks++; if (issue_valid !== 1'b0 || int'(inflight) != 2 - k || aborted !== (k == 2)) $display("FAIL t4_flush got=%0b/%0d/%0b exp=0/%0d/%0b", issue_valid, inflight, aborted, 2 - k, k == 2); else passed++;
      end
      result_valid = 1'b0;
      @(negedge clk);
      seen_done |= done;
      checks++; if ({busy, aborted} !== 2'b00) $display("FAIL t4_after got=%b exp=00", {busy, aborted}); else passed++;
      checks++; if (seen_done !== 1'b0) $display("FAIL t4_no_done got=%0b exp=0", seen_done); else passed++;
      issue_ready = 1'b0;
   endtask

   // T5/T6: issue+retire collision, async reset mid-RUN, stray result, start while busy.
   task automatic test_collide_and_reset();
      int due[$];
      int issues = 0;
      bit finished = 1'b0;
      drive_idle();
      start = 1'b1; cfg_count = 5'd4;
      @(negedge clk);
      start = 1'b0; issue_ready = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (inflight !== 3'd2) $display("FAIL t5_two_inflight got=%0d exp=2", inflight); else passed++;
      result_valid = 1'b1;
      @(negedge clk);
      result_valid = 1'b0; issue_ready = 1'b0;
      checks++; if (inflight !== 3'd2 || issue_index !== 4'd3) $display("FAIL t5_collide got=%0d/%0d exp=2/3", inflight, issue_index); else passed++;
      #2 rst_n = 1'b0;
      #1;
      checks++; if ({busy, issue_valid, done, aborted} !== 4'b0000 || inflight !== 3'd0 || issue_index !== 4'd0) $display("FAIL t6_async_reset got=%b/%0d/%0d exp=0000/0/0", {busy, issue_valid, done, aborted}, inflight, issue_index); else passed++;
      @(negedge clk);
      rst_n = 1'b1;
      result_valid = 1'b1;
      @(negedge clk);
      result_valid = 1'b0;
      checks++; if (err_underflow !== 1'b1 || inflight !== 3'd0 || busy !== 1'b0) $display("FAIL t5_stray got=%0b/%0d/%0b exp=1/0/0", err_underflow, inflight, busy); else passed++;
      start = 1'b1; cfg_count = 5'd6; issue_ready = 1'b1;
      @(negedge clk);
      cfg_count = 5'd2;
      for (int cyc = 0; cyc < 100 && !finished; cyc++) begin
         if (cyc == 3) start = 1'b0;
         if (done) begin
            finished = 1'b1;
         end else begin
            if (issue_valid) begin
               issues++;
               due.push_back(cyc + 2);
            end
            result_valid = 1'b0;
            if (due.size() > 0) begin
               if (due[0] == cyc) begin
                  result_valid = 1'b1;
                  void'(due.pop_front());
               end
            end
            @(negedge clk);
         end
      end
      drive_idle();
      checks++; if (!finished) $display("FAIL t6_done_timeout got=0 exp=1"); else passed++;
      checks++; if (issues != 6) $display("FAIL t6_start_ignored got=%0d exp=6", issues); else passed++;
      checks++; if (err_underflow !== 1'b1) $display("FAIL t5_sticky_err got=%0b exp=1", err_underflow); else passed++;
      @(negedge clk);
   endtask

   // Random traffic against a counter-level model of the batch rules.
   task automatic test_random_model();
      int due[$];
      int last_due = 0;
      bit m_busy = 1'b0, m_abrt = 1'b0, m_fin = 1'b0, m_err = 1'b0;
      int m_n = 0, m_iss = 0, m_ret = 0, m_inf = 0;
      bit e_iv, e_ab, fire, rt;
      logic [IW-1:0] e_idx;
      int cfg;
      drive_idle();
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int cyc = 0; cyc < 2500; cyc++) begin
         e_iv  = m_busy && !m_abrt && !m_fin && (m_iss < m_n) && (m_inf < MI);
         e_ab  = m_abrt && (m_inf == 0);
         e_idx = m_iss[IW-1:0];
         checks++; if (issue_valid !== e_iv) $display("FAIL rnd_issue_valid cyc=%0d got=%0b exp=%0b", cyc, issue_valid, e_iv); else passed++;
         checks++; if (issue_index !== e_idx) $display("FAIL rnd_issue_index cyc=%0d got=%0d exp=%0d", cyc, issue_index, e_idx); else passed++;
         checks++; if (int'(inflight) != m_inf) $display("FAIL rnd_inflight cyc=%0d got=%0d exp=%0d", cyc, inflight, m_inf); else passed++;
         checks++; if (busy !== m_busy) $display("FAIL rnd_busy cyc=%0d got=%0b exp=%0b", cyc, busy, m_busy); else passed++;
         checks++; if (done !== m_fin) $display("FAIL rnd_done cyc=%0d got=%0b exp=%0b", cyc, done, m_fin); else passed++;
         checks++; if (aborted !== e_ab) $display("FAIL rnd_aborted cyc=%0d got=%0b exp=%0b", cyc, aborted, e_ab); else passed++;
         checks++; if (err_underflow !== m_err) $display("FAIL rnd_err cyc=%0d got=%0b exp=%0b", cyc, err_underflow, m_err); else passed++;
         cfg         = $urandom_range(0, 20);
         cfg_count   = cfg[CW-1:0];
         start       = m_busy ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) == 0);
         abort       = ($urandom_range(0, 29) == 0);
         issue_ready = ($urandom_range(0, 3) != 0);
         result_valid = 1'b0;
         if (due.size() > 0) begin
            if (due[0] <= cyc) begin
               result_valid = 1'b1;
               void'(due.pop_front());
            end
         end else begin
            result_valid = ($urandom_range(0, 39) == 0);
         end
         fire = e_iv && issue_ready;
         if (fire) begin
            last_due = (cyc + int'($urandom_range(1, 5)) > last_due) ? cyc + int'($urandom_range(1, 5)) : last_due + 1;
            due.push_back(last_due);
         end
         rt = result_valid && (m_inf > 0) && m_busy && !m_fin;
         if (result_valid && m_inf == 0) m_err = 1'b1;
         if (!m_busy) begin
            if (start) begin
               m_busy = 1'b1; m_n = (cfg > TI) ? TI : cfg; m_iss = 0; m_ret = 0; m_abrt = 1'b0; m_fin = 1'b0;
            end
         end else if (m_fin) begin
            m_busy = 1'b0; m_fin = 1'b0;
         end else if (m_abrt) begin
            if (m_inf == 0) begin
               m_busy = 1'b0; m_abrt = 1'b0;
            end else begin
               m_inf = m_inf - int'(rt);
            end
         end else begin
            m_iss = m_iss + int'(fire);
            m_ret = m_ret + int'(rt);
            m_inf = m_inf + int'(fire) - int'(rt);
            if (abort) m_abrt = 1'b1;
            else if (m_iss == m_n && m_ret == m_n) m_fin = 1'b1;
         end
         @(negedge clk);
      end
      drive_idle();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_full_batch();
      test_credit_stall();
      test_empty_batch();
      test_abort();
      test_collide_and_reset();
      test_random_model();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
